// File: rtl/fdivsqrt_iter_seq_pkg.sv
// Shared types and configuration for the divsqrt iteration sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fdivsqrt_iter_seq_pkg;

    // Iteration-count width used by the divsqrt datapath configuration.
    localparam int FDIV_DURLEN = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } fsm_state_t;

endpackage

// File: rtl/fdivsqrt_stepctr.sv
// Loadable down-counter with clear, enable and an is-one flag; saturates at zero.
// Latency: value updates one cycle after load/en/clr.
// Backpressure: none; en is simply ignored once the count reaches zero.
module fdivsqrt_stepctr
    import fdivsqrt_iter_seq_pkg::*;
#(
    parameter int W = FDIV_DURLEN
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] cnt,
    output logic         is_one
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (en && (cnt_q != '0)) begin
            cnt_q <= cnt_q - W'(1);
        end
    end

    assign cnt    = cnt_q;
    assign is_one = (cnt_q == W'(1));

endmodule

// File: rtl/fdivsqrt_iter_seq.sv
// Divsqrt iteration sequencer: enables the datapath for CyclesE cycles, then holds DoneM.
// Latency: start accepted in IDLE, CyclesE iteration cycles, DoneM the cycle after the last.
// Backpressure: DoneM held while StallM; StartE is refused while StallE/FlushE or not IDLE.
module fdivsqrt_iter_seq
    import fdivsqrt_iter_seq_pkg::*;
#(
    parameter int DURLEN = FDIV_DURLEN
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              StartE,
    input  logic              StallE,
    input  logic              SpecialCaseE,
    input  logic [DURLEN-1:0] CyclesE,
    input  logic              FlushE,
    input  logic              StallM,
    output logic              IFDivStartE,
    output logic              IterEnE,
    output logic              BusyE,
    output logic              DoneM,
    output logic [DURLEN-1:0] StepCnt
);

    fsm_state_t state_q, state_d;
    logic       accept;
    logic       no_iter;
    logic       ctr_load;
    logic       ctr_is_one;

    assign accept   = (state_q == IDLE) && StartE && !StallE && !FlushE;
    // A zero count needs no iterations, so it takes the special-case path.
    assign no_iter  = SpecialCaseE || (CyclesE == '0);
    assign ctr_load = accept && !no_iter;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = no_iter ? DONE : BUSY;
                end
            end
            BUSY: begin
                if (ctr_is_one) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (!StallM) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (FlushE) begin
            state_d = IDLE;
        end
    end

    fdivsqrt_stepctr #(
        .W(DURLEN)
    ) u_stepctr (
        .clk      (clk),
        .reset    (reset),
        .clr      (FlushE),
        .load     (ctr_load),
        .en       (state_q == BUSY),
        .load_val (CyclesE),
        .cnt      (StepCnt),
        .is_one   (ctr_is_one)
    );

    assign IFDivStartE = accept;
    assign IterEnE     = (state_q == BUSY);
    assign DoneM       = (state_q == DONE);
    // High already in the start cycle so the hazard unit stalls the next op in time.
    assign BusyE       = (state_q == BUSY) || ctr_load;

endmodule

// File: tb/tb_fdivsqrt_iter_seq.sv
// Randomized bench: each op is turned into a per-cycle expected output schedule.
module tb_fdivsqrt_iter_seq;

    localparam int DL = 6;

    logic          clk;
    logic          reset;
    logic          StartE;
    logic          StallE;
    logic          SpecialCaseE;
    logic [DL-1:0] CyclesE;
    logic          FlushE;
    logic          StallM;
    logic          IFDivStartE;
    logic          IterEnE;
    logic          BusyE;
    logic          DoneM;
    logic [DL-1:0] StepCnt;

    int n_tests = 0;
    int n_fail  = 0;

    fdivsqrt_iter_seq #(.DURLEN(DL)) dut (
        .clk          (clk),
        .reset        (reset),
        .StartE       (StartE),
        .StallE       (StallE),
        .SpecialCaseE (SpecialCaseE),
        .CyclesE      (CyclesE),
        .FlushE       (FlushE),
        .StallM       (StallM),
        .IFDivStartE  (IFDivStartE),
        .IterEnE      (IterEnE),
        .BusyE        (BusyE),
        .DoneM        (DoneM),
        .StepCnt      (StepCnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input int st, input int it, input int bz,
                           input int dn, input int sc);
        chk({tag, ".start"}, int'(IFDivStartE), st);
        chk({tag, ".iter"},  int'(IterEnE),     it);
        chk({tag, ".busy"},  int'(BusyE),       bz);
        chk({tag, ".done"},  int'(DoneM),       dn);
        chk({tag, ".step"},  int'(StepCnt),     sc);
    endtask

    task automatic idle_inputs();
        reset        = 1'b0;
        StartE       = 1'b0;
        StallE       = 1'b0;
        SpecialCaseE = 1'b0;
        CyclesE      = '0;
        FlushE       = 1'b0;
        StallM       = 1'b0;
    endtask

    // One op: start at t=0, n iterations, DONE held for 'hold' stalled cycles,
    // optional flush/reset at cycle kill_at, optional StartE pokes during DONE.
    // Entered and left one delta after a rising edge with the DUT idle.
    task automatic run_op(input string tag, input int cyc, input bit sc, input int hold,
                          input int kill_at, input bit kill_rst, input bit poke);
        int n;
        int done_lo;
        int done_hi;
        int last;
        n       = (sc || cyc == 0) ? 0 : cyc;
        done_lo = n + 1;
        done_hi = n + 1 + hold;
        last    = (kill_at >= 1) ? kill_at + 1 : done_hi + 1;
        for (int t = 0; t <= last; t++) begin
            int e_st, e_it, e_bz, e_dn, e_sc;
            bit killed;
            killed = (kill_at >= 1) && (t > kill_at);
            idle_inputs();
            e_st = 0; e_it = 0; e_bz = 0; e_dn = 0; e_sc = 0;
            if (killed || t > done_hi) begin
                // idle: all outputs quiet
            end else if (t == 0) begin
                StartE       = 1'b1;
                CyclesE      = DL'(cyc);
                SpecialCaseE = sc;
                StallM       = 1'($urandom_range(0, 1));
                e_st = 1;
                e_bz = (n > 0) ? 1 : 0;
            end else if (t <= n) begin
                // inputs other than flush/reset must not disturb an op in flight
                StartE       = 1'($urandom_range(0, 1));
                StallE       = 1'($urandom_range(0, 1));
                SpecialCaseE = 1'($urandom_range(0, 1));
                CyclesE      = DL'($urandom);
                StallM       = 1'($urandom_range(0, 1));
                e_it = 1;
                e_bz = 1;
                e_sc = n - t + 1;
            end else begin
                StallM  = (t < done_hi) ? 1'b1 : 1'b0;
                StartE  = poke;
                CyclesE = DL'($urandom_range(1, 63));
                e_dn = 1;
            end
            if (t == kill_at) begin
                if (kill_rst) reset  = 1'b1;
                else          FlushE = 1'b1;
            end
            @(negedge clk);
            chk_all($sformatf("%s.t%0d", tag, t), e_st, e_it, e_bz, e_dn, e_sc);
            @(posedge clk);
            #1;
        end
        idle_inputs();
    endtask

    task automatic blocked(input string tag, input bit use_flush);
        idle_inputs();
        StartE  = 1'b1;
        CyclesE = DL'(7);
        StallE  = !use_flush;
        FlushE  = use_flush;
        @(negedge clk);
        chk_all({tag, ".req"}, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        idle_inputs();
        @(negedge clk);
        chk_all({tag, ".after"}, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk_all("reset", 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        run_op("basic5",   5,  1'b0, 0, -1, 1'b0, 1'b0);
        run_op("special",  20, 1'b1, 0, -1, 1'b0, 1'b0);
        run_op("stallm",   3,  1'b0, 4, -1, 1'b0, 1'b1);
        run_op("flush",    10, 1'b0, 0, 4,  1'b0, 1'b0);
        run_op("post_fl",  2,  1'b0, 0, -1, 1'b0, 1'b0);
        blocked("stalle", 1'b0);
        blocked("flushst", 1'b1);
        run_op("rst_busy", 63, 1'b0, 0, 30, 1'b1, 1'b0);
        run_op("one",      1,  1'b0, 0, -1, 1'b0, 1'b0);
        run_op("zero",     0,  1'b0, 0, -1, 1'b0, 1'b0);
        run_op("flushdn",  4,  1'b0, 2, 6,  1'b0, 1'b1);

        for (int i = 0; i < 60; i++) begin
            int  cyc, hold, n, kill_at;
            bit  sc;
            cyc  = $urandom_range(0, 63);
            sc   = ($urandom_range(0, 3) == 0);
            hold = $urandom_range(0, 3);
            n    = (sc || cyc == 0) ? 0 : cyc;
            kill_at = ($urandom_range(0, 4) == 0) ? $urandom_range(1, n + hold + 1) : -1;
            run_op($sformatf("rnd%0d", i), cyc, sc, hold, kill_at,
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
